cache_mem_arbiter: RTL and testbench

// - Shares the single DRAM port between the icache and dcache refill/writeback masters.
// - Sits below both caches and above the DRAM controller.
// - Drives transfer_in_progress, which the datapath uses to stall the pipeline during any DRAM transaction.
// - One transaction at a time, non-pipelined; dcache has priority, with a starvation guard for icache.

---
 rtl/cache_mem_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single DRAM port between the icache and dcache masters. One
// transaction at a time, non-pipelined. The dcache has priority, but after
// STARVE_LIMIT consecutive dcache grants with the icache waiting, the icache
// is served next. transfer_in_progress stalls the pipeline while a DRAM
// transaction is outstanding.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> 16-bit watchdog in BUSY; after TIMEOUT_CYCLES without
//                mem_ready the transaction is closed with 32'hDEADBEEF and
//                the sticky arb_error flag is set.
//   undefined -> BUSY waits indefinitely, arb_error tied 0.
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   i_req/i_rw/i_addr/i_wdata    icache command (byte enables implied all-ones)
//   i_ready/i_rdata              icache completion pulse and read data
//   d_req/d_rw/d_addr/d_wdata/d_byte_en  dcache command
//   d_ready/d_rdata              dcache completion pulse and read data
//   mem_req/mem_rw/mem_addr/mem_wdata/mem_byte_en  registered DRAM command
//   mem_ready/mem_rdata          DRAM completion and read data
//   transfer_in_progress         high while a DRAM transaction is outstanding
//   arb_error                    sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_req,
   input  logic                i_rw,
   input  logic [ADDR_W-1:0]   i_addr,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic                i_ready,
   output logic [DATA_W-1:0]   i_rdata,
   input  logic                d_req,
   input  logic                d_rw,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_byte_en,
   output logic                d_ready,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                mem_req,
   output logic                mem_rw,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_byte_en,
   input  logic                mem_ready,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                transfer_in_progress,
   output logic                arb_error
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      DONE   = 2'd3
   } state_t;

   typedef struct packed {
      logic              rw;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [BE_W-1:0]   byte_en;
   } cmd_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   cmd_t              cmd_q, cmd_d;
   logic              mem_req_q, mem_req_d;
   logic              tip_q, tip_d;
   logic              i_ready_q, i_ready_d;
   logic              d_ready_q, d_ready_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

   // Transaction close request, and the data to return with it
   logic              fin_c;
   logic              fin_load_c;
   logic [DATA_W-1:0] fin_data_c;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned WD_W = 16;
   localparam logic [WD_W-1:0]   WD_LAST      = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         starve_q  <= '0;
         cmd_q     <= '0;
         mem_req_q <= 1'b0;
         tip_q     <= 1'b0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_TIMEOUT_EN
         wd_q      <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         cmd_q     <= cmd_d;
         mem_req_q <= mem_req_d;
         tip_q     <= tip_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef ARB_TIMEOUT_EN
         wd_q      <= wd_d;
         err_q     <= err_d;
`endif
      end
   end

   // Arbitration, transaction tracking and next-output computation
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      cmd_d      = cmd_q;
      mem_req_d  = mem_req_q;
      tip_d      = tip_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      fin_c      = 1'b0;
      fin_load_c = 1'b0;
      fin_data_c = mem_rdata;
`ifdef ARB_TIMEOUT_EN
      wd_d       = wd_q;
      err_d      = err_q;
`endif
      case (state_q)
         IDLE: begin
            // dcache wins unless the icache has waited through STARVE_LIMIT dcache grants
            if (d_req && !(i_req && starve_q == STARVE_MAX)) begin
               state_d   = BUSY_D;
               cmd_d     = '{rw: d_rw, addr: d_addr, wdata: d_wdata, byte_en: d_byte_en};
               mem_req_d = 1'b1;
               tip_d     = 1'b1;
               if (!i_req)
                  starve_d = '0;
               else if (starve_q != CNT_SAT)
                  starve_d = starve_q + 1'b1;
            end else if (i_req) begin
               state_d   = BUSY_I;
               cmd_d     = '{rw: i_rw, addr: i_addr, wdata: i_wdata, byte_en: '1};
               mem_req_d = 1'b1;
               tip_d     = 1'b1;
               starve_d  = '0;
            end else begin
               starve_d  = '0;
            end
`ifdef ARB_TIMEOUT_EN
            wd_d = '0;
`endif
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               fin_c      = 1'b1;
               fin_load_c = !cmd_q.rw;
            end
`ifdef ARB_TIMEOUT_EN
            else if (wd_q == WD_LAST) begin
               fin_c      = 1'b1;
               fin_load_c = 1'b1;
               fin_data_c = TIMEOUT_DATA;
               err_d      = 1'b1;
            end else begin
               wd_d = wd_q + 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Close the transaction: drop the DRAM request and pulse the owner's ready
      if (fin_c) begin
         state_d   = DONE;
         mem_req_d = 1'b0;
         tip_d     = 1'b0;
         if (state_q == BUSY_I) begin
            i_ready_d = 1'b1;
            if (fin_load_c) i_rdata_d = fin_data_c;
         end else begin
            d_ready_d = 1'b1;
            if (fin_load_c) d_rdata_d = fin_data_c;
         end
      end
   end

   assign i_ready              = i_ready_q;
   assign i_rdata              = i_rdata_q;
   assign d_ready              = d_ready_q;
   assign d_rdata              = d_rdata_q;
   assign mem_req              = mem_req_q;
   assign mem_rw               = cmd_q.rw;
   assign mem_addr             = cmd_q.addr;
   assign mem_wdata            = cmd_q.wdata;
   assign mem_byte_en          = cmd_q.byte_en;
   assign transfer_in_progress = tip_q;
`ifdef ARB_TIMEOUT_EN
   assign arb_error            = err_q;
`else
   assign arb_error            = 1'b0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed scenarios plus a randomized run against a transaction-level model
// of the arbitration rules (dcache priority, starvation limit, one transaction
// at a time, ready one cycle after DRAM completion, one dead cycle after).
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;
   localparam int unsigned SL = 4;
   localparam int unsigned TO = 8;

   logic          clk;
   logic          reset_n;
   logic          i_req, i_rw, i_ready;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata, i_rdata;
   logic          d_req, d_rw, d_ready;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata, d_rdata;
   logic [BW-1:0] d_byte_en;
   logic          mem_req, mem_rw, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [BW-1:0] mem_byte_en;
   logic          transfer_in_progress, arb_error;

   int total = 0;
   int bad   = 0;

   cache_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_rw(i_rw), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byte_en(d_byte_en), .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .transfer_in_progress(transfer_in_progress), .arb_error(arb_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "bench timeout");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_rw = 1'b0; i_addr = '0; i_wdata = '0;
      d_req = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0; d_byte_en = '0;
      mem_ready = 1'b0; mem_rdata = '0;
   endtask

   task automatic test_reset();
      logic [117:0] outs;
      idle_inputs();
      reset_n = 1'b0;
      step(); step();
      outs = {mem_req, mem_rw, mem_addr, mem_wdata, mem_byte_en, i_ready, d_ready,
              transfer_in_progress, arb_error, i_rdata, d_rdata};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", outs); end
      reset_n = 1'b1;
      step();
      d_req = 1'b1; d_rw = 1'b1; d_addr = 12'h3AA; d_wdata = 32'h0BAD_F00D; d_byte_en = 4'b1100;
      step();
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 12'h3AA}) begin
         bad++; $display("FAIL reset_pre_grant got=%b/%h exp=1/3aa", mem_req, mem_addr);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({mem_req, transfer_in_progress} !== 2'b00) begin
         bad++; $display("FAIL reset_abort got=%b%b exp=00", mem_req, transfer_in_progress);
      end
      d_req = 1'b0;
      step();
      total++;
      if ({mem_req, transfer_in_progress, d_ready} !== 3'b000) begin
         bad++; $display("FAIL reset_no_ready got=%b%b%b exp=000", mem_req, transfer_in_progress, d_ready);
      end
      reset_n = 1'b1;
      step(); step();
      outs = {mem_req, mem_rw, mem_addr, mem_wdata, mem_byte_en, i_ready, d_ready,
              transfer_in_progress, arb_error, i_rdata, d_rdata};
      total++;
      if (outs !== '0) begin bad++; $display("FAIL reset_release_idle got=%h exp=0", outs); end
   endtask

   task automatic test_icache_read();
      i_req = 1'b1; i_rw = 1'b0; i_addr = 12'h040; i_wdata = $urandom;
      step();
      total++;
      if ({mem_req, mem_rw, mem_addr, mem_byte_en, transfer_in_progress} !== {1'b1, 1'b0, 12'h040, 4'hF, 1'b1}) begin
         bad++; $display("FAIL icache_grant got=%b %b %h %h %b exp=1 0 040 f 1",
                         mem_req, mem_rw, mem_addr, mem_byte_en, transfer_in_progress);
      end
      for (int k = 0; k < 2; k++) begin
         step();
         total++;
         if ({i_ready, mem_req} !== 2'b01) begin
            bad++; $display("FAIL icache_wait%0d got=%b%b exp=01", k, i_ready, mem_req);
         end
      end
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      step();
      total++;
      if ({i_ready, d_ready, mem_req, transfer_in_progress, i_rdata} !== {4'b1000, 32'h1234_5678}) begin
         bad++; $display("FAIL icache_done got=%b%b%b%b %h exp=1000 12345678",
                         i_ready, d_ready, mem_req, transfer_in_progress, i_rdata);
      end
      i_req = 1'b0; mem_ready = 1'b0; mem_rdata = $urandom;
      step();
      total++;
      if ({i_ready, mem_req} !== 2'b00) begin
         bad++; $display("FAIL icache_one_pulse got=%b%b exp=00", i_ready, mem_req);
      end
      step();
   endtask

   task automatic test_simultaneous();
      d_req = 1'b1; d_rw = 1'b1; d_addr = 12'h100; d_wdata = 32'h5555_AAAA; d_byte_en = 4'b0011;
      i_req = 1'b1; i_rw = 1'b0; i_addr = 12'h2C0; i_wdata = 32'h0;
      step();
      total++;
      if ({mem_req, mem_rw, mem_addr, mem_wdata, mem_byte_en} !== {1'b1, 1'b1, 12'h100, 32'h5555_AAAA, 4'b0011}) begin
         bad++; $display("FAIL simul_dgrant got=%b %b %h %h %b exp=1 1 100 5555aaaa 0011",
                         mem_req, mem_rw, mem_addr, mem_wdata, mem_byte_en);
      end
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
      step();
      total++;
      if ({d_ready, i_ready, d_rdata} !== {2'b10, 32'h0}) begin
         bad++; $display("FAIL simul_ddone got=%b%b %h exp=10 00000000", d_ready, i_ready, d_rdata);
      end
      d_req = 1'b0; mem_ready = 1'b0;
      step();
      total++;
      if (mem_req !== 1'b0) begin bad++; $display("FAIL simul_dead got=%b exp=0", mem_req); end
      step();
      total++;
      if ({mem_req, mem_rw, mem_addr, mem_byte_en} !== {1'b1, 1'b0, 12'h2C0, 4'hF}) begin
         bad++; $display("FAIL simul_igrant got=%b %b %h %h exp=1 0 2c0 f", mem_req, mem_rw, mem_addr, mem_byte_en);
      end
      mem_ready = 1'b1; mem_rdata = 32'hA5A5_0F0F;
      step();
      total++;
      if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'hA5A5_0F0F}) begin
         bad++; $display("FAIL simul_idone got=%b%b %h exp=10 a5a50f0f", i_ready, d_ready, i_rdata);
      end
      i_req = 1'b0; mem_ready = 1'b0;
      step(); step();
   endtask

   task automatic test_starvation();
      int n = 0;
      int streak = 0;
      bit exp_d;
      i_req = 1'b1; i_rw = 1'b0; i_addr = 12'h222;
      d_req = 1'b1; d_rw = 1'b0; d_addr = 12'h111; d_byte_en = 4'hF;
      mem_ready = 1'b1; mem_rdata = 32'h7777_1111;
      for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
         step();
         if (i_ready || d_ready) begin
            exp_d  = (streak != int'(SL));
            streak = exp_d ? streak + 1 : 0;
            total++;
            if ({i_ready, d_ready} !== (exp_d ? 2'b01 : 2'b10)) begin
               bad++; $display("FAIL starve_order n=%0d got=%b%b exp=%s", n, i_ready, d_ready, exp_d ? "D" : "I");
            end
            n++;
         end
      end
      total++;
      if (n != 10) begin bad++; $display("FAIL starve_count got=%0d exp=10", n); end
      idle_inputs();
      step(); step();
   endtask

   task automatic test_drop_req();
      int extra = 0;
      d_req = 1'b1; d_rw = 1'b0; d_addr = 12'h055; d_byte_en = 4'hF;
      step();
      total++;
      if ({mem_req, mem_addr} !== {1'b1, 12'h055}) begin
         bad++; $display("FAIL drop_grant got=%b %h exp=1 055", mem_req, mem_addr);
      end
      d_req = 1'b0;
      step();
      total++;
      if (mem_req !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b exp=1", mem_req); end
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      step();
      total++;
      if ({d_ready, i_ready, d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
         bad++; $display("FAIL drop_done got=%b%b %h exp=10 cafef00d", d_ready, i_ready, d_rdata);
      end
      mem_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (mem_req || d_ready || i_ready) extra++;
      end
      total++;
      if (extra != 0) begin bad++; $display("FAIL drop_regrant got=%0d exp=0", extra); end
   endtask

   task automatic test_random(input int ncyc);
      bit busy, done_now, done_next, grant_next, owner, win, i_act, d_act;
      int lat, streak;
      logic [48:0] exp_cmd;
      logic [DW-1:0] m_i, m_d;
      idle_inputs();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      busy = 0; done_next = 0; grant_next = 0; owner = 0; win = 0;
      i_act = 0; d_act = 0; lat = 0; streak = 0; m_i = '0; m_d = '0; exp_cmd = '0;
      for (int c = 0; c < ncyc; c++) begin
         step();
         done_now = done_next;
         total++;
         if ({i_ready, d_ready} !== {done_now && !owner, done_now && owner}) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", c, i_ready, d_ready,
                            done_now && !owner, done_now && owner);
         end
         if (done_now) begin
            total++;
            if ((owner ? d_rdata : i_rdata) !== (owner ? m_d : m_i)) begin
               bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c,
                               owner ? d_rdata : i_rdata, owner ? m_d : m_i);
            end
            busy = 0;
         end
         if (grant_next) begin
            busy = 1; owner = win; lat = $urandom_range(0, 3);
         end
         total++;
         if ({mem_req, transfer_in_progress} !== {busy, busy}) begin
            bad++; $display("FAIL rnd_req cyc=%0d got=%b%b exp=%b%b", c, mem_req, transfer_in_progress, busy, busy);
         end
         if (busy) begin
            total++;
            if ({mem_rw, mem_addr, mem_wdata, mem_byte_en} !== exp_cmd) begin
               bad++; $display("FAIL rnd_cmd cyc=%0d got=%h exp=%h", c,
                               {mem_rw, mem_addr, mem_wdata, mem_byte_en}, exp_cmd);
            end
         end
         // DRAM side: random latency, spurious mem_ready outside BUSY
         done_next = 0; grant_next = 0;
         mem_rdata = $urandom;
         if (busy) begin
            if (lat == 0) begin
               mem_ready = 1'b1; done_next = 1;
               if (!exp_cmd[48]) begin
                  if (owner) m_d = mem_rdata; else m_i = mem_rdata;
               end
            end else begin
               mem_ready = 1'b0; lat--;
            end
         end else begin
            mem_ready = ($urandom_range(0, 3) == 0);
         end
         // Requesters
         if (done_now) begin
            if (owner) d_act = 0; else i_act = 0;
         end
         if (busy && $urandom_range(0, 7) == 0) begin
            if (owner) d_req = 1'b0; else i_req = 1'b0;
         end
         if (!i_act) begin
            i_rw = 1'($urandom); i_addr = AW'($urandom); i_wdata = $urandom;
            i_act = !(done_now && !owner) && ($urandom_range(0, 2) == 0);
            i_req = i_act;
         end
         if (!d_act) begin
            d_rw = 1'($urandom); d_addr = AW'($urandom); d_wdata = $urandom; d_byte_en = BW'($urandom);
            d_act = !(done_now && owner) && ($urandom_range(0, 2) == 0);
            d_req = d_act;
         end
         // Arbitration decision for a free cycle
         if (!busy && !done_now) begin
            if (d_req && !(i_req && streak == int'(SL))) begin
               win = 1; grant_next = 1;
               exp_cmd = {d_rw, d_addr, d_wdata, d_byte_en};
               streak = i_req ? streak + 1 : 0;
            end else if (i_req) begin
               win = 0; grant_next = 1;
               exp_cmd = {i_rw, i_addr, i_wdata, 4'hF};
               streak = 0;
            end else begin
               streak = 0;
            end
         end
      end
      idle_inputs();
      mem_ready = 1'b1;
      step(); step(); step(); step();
      mem_ready = 1'b0;
      step(); step();
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      int k = 0;
      i_req = 1'b1; i_rw = 1'b0; i_addr = 12'h0AB; mem_ready = 1'b0;
      step();
      while (!i_ready && k < 20) begin
         step();
         k++;
      end
      total++;
      if (k != int'(TO)) begin bad++; $display("FAIL timeout_latency got=%0d exp=%0d", k, TO); end
      total++;
      if ({arb_error, mem_req, i_rdata} !== {2'b10, 32'hDEADBEEF}) begin
         bad++; $display("FAIL timeout_done got=%b%b %h exp=10 deadbeef", arb_error, mem_req, i_rdata);
      end
      i_req = 1'b0;
      step(); step();
      total++;
      if ({arb_error, mem_req, transfer_in_progress} !== 3'b100) begin
         bad++; $display("FAIL timeout_sticky got=%b%b%b exp=100", arb_error, mem_req, transfer_in_progress);
      end
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      test_reset();
      test_icache_read();
      test_simultaneous();
      test_starvation();
      test_drop_req();
      test_random(1500);
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
